// File: rtl/dzcpu_useq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dzcpu_useq_pkg: shared constants for the dzcpu microcode sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dzcpu_useq_pkg;

  localparam int c_flow_msb = 12;
  localparam int c_flow_lsb = 9;
  localparam int c_op_msb   = 8;
  localparam int c_op_lsb   = 4;
  localparam int c_opnd_msb = 3;
  localparam int c_opnd_lsb = 0;

  // Flow-control codes held in the top nibble of each ROM word; 10-15 act as OP.
  localparam logic [3:0] c_flow_op           = 4'd0;
  localparam logic [3:0] c_flow_inc          = 4'd1;
  localparam logic [3:0] c_flow_eof          = 4'd2;
  localparam logic [3:0] c_flow_inc_eof      = 4'd3;
  localparam logic [3:0] c_flow_eof_fu       = 4'd4;
  localparam logic [3:0] c_flow_inc_eof_fu   = 4'd5;
  localparam logic [3:0] c_flow_inc_eof_z    = 4'd6;
  localparam logic [3:0] c_flow_inc_eof_nz   = 4'd7;
  localparam logic [3:0] c_flow_update_flags = 4'd8;
  localparam logic [3:0] c_flow_nop          = 4'd9;

  localparam logic [4:0] c_op_jcb = 5'h1f;

  localparam logic [1:0] c_st_fetch    = 2'd0;
  localparam logic [1:0] c_st_decode   = 2'd1;
  localparam logic [1:0] c_st_cbdecode = 2'd2;
  localparam logic [1:0] c_st_exec     = 2'd3;

  function automatic logic flow_pc_inc(input logic [3:0] flow);
    return (flow == c_flow_inc) || (flow == c_flow_inc_eof) ||
           (flow == c_flow_inc_eof_fu) || (flow == c_flow_inc_eof_z) ||
           (flow == c_flow_inc_eof_nz);
  endfunction

  function automatic logic flow_upd_flags(input logic [3:0] flow);
    return (flow == c_flow_eof_fu) || (flow == c_flow_inc_eof_fu) ||
           (flow == c_flow_update_flags);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dzcpu_useq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dzcpu_useq: opcode fetch, flow-LUT decode and micro-PC sequencing    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dzcpu_useq
  import dzcpu_useq_pkg::*;
(
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMop,
  input  logic        iMemReady,
  input  logic        iZeroFlag,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  input  logic [12:0] iUop,
  output logic [7:0]  oLutMop,
  output logic [7:0]  oUopAddr,
  output logic        oUopValid,
  output logic [4:0]  oOp,
  output logic [3:0]  oOperand,
  output logic        oPcInc,
  output logic        oUpdateFlags,
  output logic        oEof,
  output logic        oCbMode
);

  logic [1:0] r_state, w_state_nxt;
  logic [7:0] r_upc, w_upc_nxt;
  logic [7:0] r_ir, w_ir_nxt;
  logic       r_cbmode, w_cbmode_nxt;

  logic [3:0] w_flow;
  logic [4:0] w_op;
  logic [3:0] w_operand;
  logic       w_term;
  logic       w_cond;

  assign w_flow    = iUop[c_flow_msb:c_flow_lsb];
  assign w_op      = iUop[c_op_msb:c_op_lsb];
  assign w_operand = iUop[c_opnd_msb:c_opnd_lsb];

  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state  <= c_st_fetch;
      r_upc    <= 8'h00;
      r_ir     <= 8'h00;
      r_cbmode <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_upc    <= w_upc_nxt;
      r_ir     <= w_ir_nxt;
      r_cbmode <= w_cbmode_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_upc_nxt    = r_upc;
    w_ir_nxt     = r_ir;
    w_cbmode_nxt = r_cbmode;
    if (iMemReady) begin
      case (r_state)
        c_st_fetch: begin
          w_ir_nxt     = iMop;
          w_cbmode_nxt = 1'b0;
          w_state_nxt  = c_st_decode;
        end
        // Shared by both decode paths; cbmode picks which LUT supplies the start.
        c_st_decode: begin
          w_upc_nxt   = r_cbmode ? iCbFlowIdx : iFlowIdx;
          w_state_nxt = c_st_exec;
        end
        c_st_cbdecode: begin
          w_ir_nxt     = iMop;
          w_cbmode_nxt = 1'b1;
          w_state_nxt  = c_st_decode;
        end
        c_st_exec: begin
          if (w_term) begin
            w_upc_nxt   = 8'h00;
            w_state_nxt = c_st_fetch;
          end else if (w_op == c_op_jcb) begin
            w_state_nxt = c_st_cbdecode;
          end else begin
            w_upc_nxt = r_upc + 8'd1;
          end
        end
        default: w_state_nxt = c_st_fetch;
      endcase
    end
  end

  always_comb begin
    oUopValid    = 1'b0;
    oPcInc       = 1'b0;
    oUpdateFlags = 1'b0;
    oEof         = 1'b0;
    oOp          = 5'd0;
    oOperand     = 4'd0;
    w_term       = 1'b0;
    w_cond       = (w_flow == c_flow_inc_eof_z) || (w_flow == c_flow_inc_eof_nz);
    if (r_state == c_st_exec) begin
      oOp      = w_op;
      oOperand = w_operand;
      case (w_flow)
        c_flow_eof, c_flow_inc_eof, c_flow_eof_fu, c_flow_inc_eof_fu: w_term = 1'b1;
        c_flow_inc_eof_z:  w_term = iZeroFlag;
        c_flow_inc_eof_nz: w_term = ~iZeroFlag;
        default:           w_term = 1'b0;
      endcase
      // A taken conditional exit only retires the instruction; its uop is not executed.
      if (iMemReady) begin
        oUopValid    = ~(w_term & w_cond);
        oPcInc       = flow_pc_inc(w_flow);
        oUpdateFlags = flow_upd_flags(w_flow);
        oEof         = w_term;
      end
    end
  end

  assign oLutMop  = r_ir;
  assign oUopAddr = r_upc;
  assign oCbMode  = r_cbmode;

endmodule
`default_nettype wire

// File: tb/tb_dzcpu_useq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dzcpu_useq: trace-model bench for the dzcpu microcode sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dzcpu_useq;
  import dzcpu_useq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mop = 8'h31;
  logic        ready = 1'b1;
  logic        zf = 1'b0;
  logic [7:0]  flow_idx, cb_flow_idx;
  logic [12:0] uop;
  logic [7:0]  lut_mop, uop_addr;
  logic        uop_valid, pc_inc, upd_flags, eof, cb_mode;
  logic [4:0]  op;
  logic [3:0]  operand;

  dzcpu_useq dut (
    .iClock(clk), .iReset(rst), .iMop(mop), .iMemReady(ready), .iZeroFlag(zf),
    .iFlowIdx(flow_idx), .iCbFlowIdx(cb_flow_idx), .iUop(uop),
    .oLutMop(lut_mop), .oUopAddr(uop_addr), .oUopValid(uop_valid), .oOp(op),
    .oOperand(operand), .oPcInc(pc_inc), .oUpdateFlags(upd_flags), .oEof(eof),
    .oCbMode(cb_mode)
  );

  always #5 clk = ~clk;

  logic [12:0] rom [256];
  logic [7:0]  lut [256];
  logic [7:0]  cblut [256];

  always_comb begin
    uop         = rom[uop_addr];
    flow_idx    = lut[lut_mop];
    cb_flow_idx = cblut[lut_mop];
  end

  function automatic logic [12:0] mk(input int f, input int o, input int d);
    return {f[3:0], o[4:0], d[3:0]};
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = mk(9, 0, 0); lut[i] = 8'd0; cblut[i] = 8'd0;
    end
    rom[0]   = mk(3, 1, 0);
    rom[1]   = mk(1, 2, 1);  rom[2]  = mk(1, 3, 2);  rom[3]  = mk(0, 4, 3);  rom[4]  = mk(3, 5, 4);
    rom[5]   = mk(0, 6, 1);  rom[6]  = mk(9, 0, 0);  rom[7]  = mk(8, 7, 2);  rom[8]  = mk(3, 8, 3);
    rom[13]  = mk(1, 6, 5);  rom[14] = mk(0, 7, 3);  rom[15] = mk(0, 31, 0); rom[16] = mk(5, 8, 9);
    rom[17]  = mk(1, 9, 1);  rom[18] = mk(0, 10, 2); rom[19] = mk(6, 11, 5);
    rom[20]  = mk(0, 12, 6); rom[21] = mk(9, 0, 0);  rom[22] = mk(3, 13, 7);
    rom[23]  = mk(7, 14, 8); rom[24] = mk(3, 15, 9);
    rom[25]  = mk(12, 16, 10); rom[26] = mk(2, 17, 11);
    rom[254] = mk(1, 18, 12); rom[255] = mk(0, 19, 13);
    lut[8'h31] = 8'd1;  lut[8'h20] = 8'd17; lut[8'hCB] = 8'd13; lut[8'h05] = 8'd5;
    lut[8'h10] = 8'd254; lut[8'h28] = 8'd23; lut[8'h40] = 8'd25;
    cblut[8'h7C] = 8'd16;
  end

  typedef struct {
    bit         ready;
    bit         isuop;
    bit         chkaddr;
    logic [7:0] addr;
    logic [7:0] mop;
    logic [3:0] strb;   // {valid, pcinc, updflags, eof}
    logic [8:0] opnd;
    bit         cb;
    logic [7:0] ir;
  } ent_t;

  ent_t exp_q[$];
  ent_t cur;
  bit   cur_vld = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   obs_cyc, obs_pc, obs_eof;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected trace of one instruction, walked straight from the ROM/LUT tables.
  task automatic build(input logic [7:0] opc, input logic [7:0] cbop, input bit z,
                       input int st_addr, input int st_n);
    ent_t e;
    logic [7:0] a, ir;
    logic [12:0] u;
    logic [3:0] f;
    bit cb, stalled, term, cond;
    exp_q.delete();
    e = '{default: 0}; e.ready = 1; e.mop = opc;
    exp_q.push_back(e); exp_q.push_back(e);
    a = lut[opc]; ir = opc; cb = 0; stalled = 0;
    for (int n = 0; n < 64; n++) begin
      u = rom[a]; f = u[12:9];
      if (!stalled && int'(a) == st_addr) begin
        stalled = 1;
        for (int k = 0; k < st_n; k++) begin
          e = '{default: 0}; e.mop = ir; e.chkaddr = 1; e.addr = a;
          exp_q.push_back(e);
        end
      end
      cond = (f == 6) || (f == 7);
      term = (f >= 2 && f <= 5) || (f == 6 && z) || (f == 7 && !z);
      e = '{default: 0};
      e.ready = 1; e.isuop = 1; e.chkaddr = 1; e.addr = a; e.mop = ir;
      e.cb = cb; e.ir = ir; e.opnd = u[8:0];
      e.strb = {!(term && cond), (f inside {1, 3, 5, 6, 7}), (f inside {4, 5, 8}), term};
      exp_q.push_back(e);
      if (term) break;
      if (u[8:4] == c_op_jcb) begin
        e = '{default: 0}; e.ready = 1; e.mop = cbop;
        exp_q.push_back(e); exp_q.push_back(e);
        ir = cbop; cb = 1; a = cblut[cbop];
      end else begin
        a = a + 8'd1;
      end
    end
  endtask

  task automatic run_instr(input logic [7:0] opc, input logic [7:0] cbop, input bit z,
                           input int st_addr, input int st_n, input int rst_at);
    build(opc, cbop, z, st_addr, st_n);
    obs_cyc = 0; obs_pc = 0; obs_eof = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      mop = exp_q[i].mop; ready = exp_q[i].ready; zf = z; rst = (i == rst_at);
      cur = exp_q[i]; cur_vld = 1'b1;
      if (i == rst_at) break;
    end
    @(negedge clk); #1;
    cur_vld = 1'b0;
  endtask

  always @(negedge clk) begin
    if (cur_vld) begin
      chk("strobes", {28'd0, uop_valid, pc_inc, upd_flags, eof}, {28'd0, cur.strb});
      if (cur.chkaddr) chk("uop_addr", {24'd0, uop_addr}, {24'd0, cur.addr});
      if (cur.isuop) begin
        chk("op_operand", {23'd0, op, operand}, {23'd0, cur.opnd});
        chk("cb_mode", {31'd0, cb_mode}, {31'd0, cur.cb});
        chk("ir", {24'd0, lut_mop}, {24'd0, cur.ir});
      end
      obs_cyc++;
      obs_pc += int'(pc_inc);
      if (eof) obs_eof = int'(uop_addr);
    end
  end

  task automatic chk_reset_state(input string tag);
    @(posedge clk); #1;
    rst = 1'b0; ready = 1'b0; mop = 8'h31;
    @(negedge clk);
    chk({tag, "_addr"}, {24'd0, uop_addr}, 32'd0);
    chk({tag, "_ir"}, {24'd0, lut_mop}, 32'd0);
    chk({tag, "_cb"}, {31'd0, cb_mode}, 32'd0);
    chk({tag, "_strobes"}, {28'd0, uop_valid, pc_inc, upd_flags, eof}, 32'd0);
    chk({tag, "_op"}, {23'd0, op, operand}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_fetch_hold_ir"}, {24'd0, lut_mop}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; ready = 1'b1; mop = 8'h31;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("por_addr", {24'd0, uop_addr}, 32'd0);
    chk("por_ir", {24'd0, lut_mop}, 32'd0);
    chk("por_strobes", {27'd0, uop_valid, pc_inc, upd_flags, eof, cb_mode}, 32'd0);
    chk("por_op", {23'd0, op, operand}, 32'd0);

    run_instr(8'h31, 8'h00, 1'b0, -1, 0, -1);
    chk("ldsp_cycles", obs_cyc, 6); chk("ldsp_pcinc", obs_pc, 3); chk("ldsp_eof", obs_eof, 4);

    run_instr(8'h20, 8'h00, 1'b1, -1, 0, -1);
    chk("jrnz_z1_cycles", obs_cyc, 5); chk("jrnz_z1_eof", obs_eof, 19); chk("jrnz_z1_pcinc", obs_pc, 2);

    run_instr(8'h20, 8'h00, 1'b0, -1, 0, -1);
    chk("jrnz_z0_cycles", obs_cyc, 8); chk("jrnz_z0_eof", obs_eof, 22);

    run_instr(8'hCB, 8'h7C, 1'b0, -1, 0, -1);
    chk("cb_cycles", obs_cyc, 8); chk("cb_eof", obs_eof, 16); chk("cb_pcinc", obs_pc, 2);

    run_instr(8'h05, 8'h00, 1'b0, 6, 3, -1);
    chk("stall_cycles", obs_cyc, 9); chk("stall_eof", obs_eof, 8);

    run_instr(8'h99, 8'h00, 1'b0, -1, 0, -1);
    chk("unmapped_cycles", obs_cyc, 3); chk("unmapped_eof", obs_eof, 0); chk("unmapped_pcinc", obs_pc, 1);

    run_instr(8'h10, 8'h00, 1'b0, -1, 0, -1);
    chk("wrap_cycles", obs_cyc, 5); chk("wrap_eof", obs_eof, 0);

    run_instr(8'h28, 8'h00, 1'b0, -1, 0, -1);
    chk("nz_taken_eof", obs_eof, 23);
    run_instr(8'h28, 8'h00, 1'b1, -1, 0, -1);
    chk("nz_fall_eof", obs_eof, 24);

    run_instr(8'h40, 8'h00, 1'b0, -1, 0, -1);
    chk("flow12_eof", obs_eof, 26); chk("flow12_pcinc", obs_pc, 0);

    run_instr(8'hCB, 8'h00, 1'b0, -1, 0, -1);
    chk("cb_unmapped_cycles", obs_cyc, 8); chk("cb_unmapped_eof", obs_eof, 0);

    run_instr(8'h31, 8'h00, 1'b0, -1, 0, 4);
    chk("rst_mid_noeof", obs_eof, -1);
    chk_reset_state("rst_mid");

    run_instr(8'hCB, 8'h7C, 1'b0, -1, 0, 6);
    chk_reset_state("rst_cb");

    run_instr(8'h31, 8'h00, 1'b0, -1, 0, -1);
    chk("after_rst_cycles", obs_cyc, 6); chk("after_rst_eof", obs_eof, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
